// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE->BUSY->DONE, 2-cycle min latency, stall held while waiting on mem_ack.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] ld_data,
  output logic [2:0]  ld_func3,
  output logic        bus_err,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic [1:0]  off_q;
  logic [1:0]  off_eff;
  logic        is_byte, is_half;
  logic        trap, start, ack_hit, timeout_hit;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;

  // Codes 011/110/111 fall through to word size.
  assign is_byte = (func3[1:0] == 2'b00);
  assign is_half = (func3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap    = (is_half & addr[0]) | (!is_byte & !is_half & (addr[1:0] != 2'b00));
  assign off_eff = addr[1:0];
`else
  assign trap    = 1'b0;
  assign off_eff = is_byte ? addr[1:0] : (is_half ? {addr[1], 1'b0} : 2'b00);
`endif

  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = st_data;
    if (is_byte) begin
      wdata_c = {4{st_data[7:0]}};
      if (req_we) wstrb_c = 4'b0001 << off_eff;
    end else if (is_half) begin
      wdata_c = {2{st_data[15:0]}};
      if (req_we) wstrb_c = 4'b0011 << off_eff;
    end else if (req_we) begin
      wstrb_c = 4'b1111;
    end
  end

  assign start       = (state == IDLE) && req_valid && !trap;
  assign ack_hit     = (state == BUSY) && mem_ack;
  assign timeout_hit = (state == BUSY) && !mem_ack && ((wait_cnt + 16'd1) == TIMEOUT_CNT);
  assign stall       = start || (state == BUSY);
  assign resp_valid  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = trap ? DONE : BUSY;
      BUSY:    if (ack_hit || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      off_q      <= 2'd0;
      ld_data    <= 32'd0;
      ld_func3   <= 3'd0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
      wait_cnt   <= 16'd0;
    end else begin
      state      <= state_nxt;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= req_we;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= wdata_c;
        mem_wstrb <= wstrb_c;
        off_q     <= off_eff;
        ld_func3  <= func3;
        wait_cnt  <= 16'd0;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      if ((state == IDLE) && req_valid && trap) begin
        misaligned <= 1'b1;
        ld_data    <= 32'd0;
        ld_func3   <= func3;
      end
`endif
      if (ack_hit) begin
        mem_req <= 1'b0;
        ld_data <= mem_we ? 32'd0 : (mem_rdata >> {off_q, 3'b000});
      end else if (timeout_hit) begin
        mem_req <= 1'b0;
        bus_err <= 1'b1;
        ld_data <= 32'd0;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4; outputs sampled 1-2 time units after the rising edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  func3;
  logic [31:0] addr, st_data;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] ld_data;
  logic [2:0]  ld_func3;
  logic        bus_err, misaligned;

  int n_cmp = 0;
  int n_err = 0;

  int          lat, stall_cyc, busy_cyc;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_wstrb;
  logic [2:0]  o_f3;
  logic        o_we, o_err, o_mis, o_req_done, o_rv_after, held_ok;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .func3(func3),
    .addr(addr), .st_data(st_data), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .ld_data(ld_data), .ld_func3(ld_func3),
    .bus_err(bus_err), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and acks on BUSY cycle number ack_at (-1: never ack).
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int ack_at);
    logic done;
    done = 1'b0;
    lat = 0; stall_cyc = 0; busy_cyc = 0; held_ok = 1'b1;
    o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 1'b0;
    req_valid = 1'b1; req_we = we; func3 = f3; addr = a; st_data = sd; mem_rdata = rd;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_ack = mem_req && (busy_cyc == ack_at);
      #1;
      if (stall) stall_cyc++;
      if (resp_valid) begin
        done = 1'b1;
      end else begin
        if (mem_req) begin
          if (busy_cyc == 0) begin
            o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb; o_we = mem_we;
          end else if (o_addr !== mem_addr || o_wdata !== mem_wdata ||
                       o_wstrb !== mem_wstrb || o_we !== mem_we) begin
            held_ok = 1'b0;
          end
          busy_cyc++;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    check("resp_seen", {31'd0, done}, 32'd1);
    o_ld = ld_data; o_f3 = ld_func3; o_err = bus_err; o_mis = misaligned; o_req_done = mem_req;
    req_valid = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    o_rv_after = resp_valid;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; func3 = 3'b000;
    addr = '0; st_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // lw, ack in first BUSY cycle
    run_req(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0);
    check("lw_addr", o_addr, 32'h0000_0100);
    check("lw_latency", lat, 2);
    check("lw_stall_cycles", stall_cyc, 2);
    check("lw_ld_data", o_ld, 32'hDEAD_BEEF);
    check("lw_wstrb", {28'd0, o_wstrb}, 32'd0);
    check("lw_we", {31'd0, o_we}, 32'd0);
    check("lw_req_in_done", {31'd0, o_req_done}, 32'd0);
    check("lw_done_one_cycle", {31'd0, o_rv_after}, 32'd0);

    run_req(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h8011_2233, 0);
    check("lb_ld_data", o_ld, 32'h0000_0080);
    check("lb_func3", {29'd0, o_f3}, 32'd0);
    check("lb_addr", o_addr, 32'h0000_0100);

    run_req(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 0);
    check("sh_wstrb", {28'd0, o_wstrb}, 32'h0000_000C);
    check("sh_wdata", o_wdata, 32'hABCD_ABCD);
    check("sh_we", {31'd0, o_we}, 32'd1);
    check("sh_addr", o_addr, 32'h0000_0200);

    run_req(1'b1, 3'b000, 32'h0000_0101, 32'h1234_565A, 32'd0, 0);
    check("sb_wstrb", {28'd0, o_wstrb}, 32'h0000_0002);
    check("sb_wdata", o_wdata, 32'h5A5A_5A5A);

    // sw with ack on third BUSY cycle
    run_req(1'b1, 3'b010, 32'h0000_030C, 32'h1234_5678, 32'd0, 2);
    check("sw_wstrb", {28'd0, o_wstrb}, 32'h0000_000F);
    check("sw_wdata", o_wdata, 32'h1234_5678);
    check("sw_latency", lat, 4);
    check("sw_busy_cycles", busy_cyc, 3);
    check("sw_held", {31'd0, held_ok}, 32'd1);

    run_req(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'hCAFE_0000, 0);
    check("lhu_ld_data", o_ld, 32'h0000_CAFE);
    check("lhu_func3", {29'd0, o_f3}, 32'd5);

    // func3=111 behaves as sw on the bus
    run_req(1'b1, 3'b111, 32'h0000_0104, 32'hA5A5_0F0F, 32'd0, 0);
    check("f111_wstrb", {28'd0, o_wstrb}, 32'h0000_000F);
    check("f111_wdata", o_wdata, 32'hA5A5_0F0F);

    // no ack: times out after TIMEOUT=4 BUSY cycles
    run_req(1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'hFFFF_FFFF, -1);
    check("to_busy_cycles", busy_cyc, 4);
    check("to_bus_err", {31'd0, o_err}, 32'd1);
    check("to_ld_data", o_ld, 32'd0);
    check("to_req_dropped", {31'd0, o_req_done}, 32'd0);
    check("to_held", {31'd0, held_ok}, 32'd1);
    check("to_err_cleared", {31'd0, bus_err}, 32'd0);

    run_req(1'b0, 3'b001, 32'h0000_0101, 32'd0, 32'h1122_3344, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh_mis_flag", {31'd0, o_mis}, 32'd1);
    check("lh_mis_no_req", busy_cyc, 0);
    check("lh_mis_stall", stall_cyc, 0);
    check("lh_mis_latency", lat, 1);
    check("lh_mis_ld_data", o_ld, 32'd0);
`else
    check("lh_mis_flag", {31'd0, o_mis}, 32'd0);
    check("lh_mis_addr", o_addr, 32'h0000_0100);
    check("lh_mis_ld_data", o_ld, 32'h1122_3344);
    check("lh_mis_latency", lat, 2);
`endif

    // reset in the middle of BUSY, then a late ack
    req_valid = 1'b1; req_we = 1'b0; func3 = 3'b010; addr = 32'h0000_0400; mem_ack = 1'b0;
    @(posedge clk); #1;
    check("rb_in_busy", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rb_req_cleared", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("rb_no_resp", {31'd0, resp_valid}, 32'd0);
    check("rb_no_req", {31'd0, mem_req}, 32'd0);
    check("rb_no_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("rb_no_resp_late", {31'd0, resp_valid}, 32'd0);

    run_req(1'b0, 3'b010, 32'h0000_0600, 32'd0, 32'h0BAD_F00D, 0);
    check("rb_idle_latency", lat, 2);
    check("rb_idle_ld_data", o_ld, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
